md5_crack_ctrl: RTL



---
 rtl/md5_crack_pkg.sv | 28 ++
 rtl/bcd_incr.sv | 32 +++
 rtl/md5_crack_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/md5_crack_pkg.sv
// Shared types and helpers for the md5 password-candidate controller.
// Candidates are 8 packed BCD digits; the md5 core consumes them as 8 ASCII bytes.
package md5_crack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    DRAIN,
    FINISH
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam int         DIGITS      = 8;
  localparam int         MD5_LATENCY = 67;

  // MSD character lands in the top byte, so "12345678" reads as 64'h3132333435363738.
  function automatic logic [8*DIGITS-1:0] bcd_to_ascii(input logic [4*DIGITS-1:0] bcd);
    logic [8*DIGITS-1:0] a;
    a = '0;
    for (int i = 0; i < DIGITS; i++) begin
      a[i*8 +: 8] = ASCII_ZERO + {4'h0, bcd[i*4 +: 4]};
    end
    return a;
  endfunction

endpackage

// File: rtl/bcd_incr.sv
// Combinational 8-digit packed-BCD adder of a constant STRIDE (1..9).
// carry_out flags a decimal overflow out of the most significant digit.
module bcd_incr
  import md5_crack_pkg::*;
#(
  parameter int STRIDE = 1
) (
  input  logic [4*DIGITS-1:0] a,
  output logic [4*DIGITS-1:0] sum,
  output logic                carry_out
);

  always_comb begin
    logic [4:0] t;
    logic       c;
    sum = '0;
    t   = '0;
    c   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      t = {1'b0, a[i*4 +: 4]} + {4'b0, c} + ((i == 0) ? 5'(STRIDE) : 5'd0);
      if (t > 5'd9) begin
        sum[i*4 +: 4] = 4'(t - 5'd10);
        c             = 1'b1;
      end else begin
        sum[i*4 +: 4] = t[3:0];
        c             = 1'b0;
      end
    end
    carry_out = c;
  end

endmodule

// File: rtl/md5_crack_ctrl.sv
// Walks an inclusive BCD password range, feeds each candidate to the md5 core
// and reports the first candidate whose digest equals the latched target.
module md5_crack_ctrl
  import md5_crack_pkg::*;
#(
  parameter int STRIDE  = 1,
  parameter int TRIED_W = 27
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        first_bcd,
  input  logic [31:0]        last_bcd,
  input  logic [127:0]       target,
  input  logic               abort,
  output logic [63:0]        md5_in,
  output logic               md5_start,
  input  logic               md5_done,
  input  logic [127:0]       md5_out,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [63:0]        found_pw,
  output logic [TRIED_W-1:0] tried
);

  // Handshake: md5_start is a one-cycle request; the core answers with a
  // one-cycle md5_done and md5_out is only meaningful in that cycle.
  state_e             state_q, state_d;
  logic [31:0]        cand_q, cand_d;
  logic [31:0]        last_q, last_d;
  logic [127:0]       target_q, target_d;
  logic               found_q, found_d;
  logic [63:0]        found_pw_q, found_pw_d;
  logic [TRIED_W-1:0] tried_q, tried_d;
  logic [31:0]        nxt;
  logic               nxt_carry;

  bcd_incr #(.STRIDE(STRIDE)) u_incr (
    .a         (cand_q),
    .sum       (nxt),
    .carry_out (nxt_carry)
  );

  assign md5_in   = bcd_to_ascii(cand_q);
  assign found    = found_q;
  assign found_pw = found_pw_q;
  assign tried    = tried_q;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    last_d     = last_q;
    target_d   = target_q;
    found_d    = found_q;
    found_pw_d = found_pw_q;
    tried_d    = tried_q;
    md5_start  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cand_d     = first_bcd;
          last_d     = last_bcd;
          target_d   = target;
          found_d    = 1'b0;
          found_pw_d = '0;
          tried_d    = '0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if (abort || (cand_q > last_q)) state_d = FINISH;
        else                            state_d = ISSUE;
      end
      ISSUE: begin
        busy      = 1'b1;
        md5_start = 1'b1;
        // The core has been started either way; an abort must let it drain.
        state_d   = abort ? DRAIN : WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (md5_done) begin
          tried_d = tried_q + {{(TRIED_W-1){1'b0}}, 1'b1};
          if (md5_out == target_q) begin
            found_d    = 1'b1;
            found_pw_d = md5_in;
            state_d    = FINISH;
          end else if (abort || nxt_carry || (nxt > last_q)) begin
            state_d = FINISH;
          end else begin
            cand_d  = nxt;
            state_d = ISSUE;
          end
        end else if (abort) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (md5_done) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      last_q     <= '0;
      target_q   <= '0;
      found_q    <= 1'b0;
      found_pw_q <= '0;
      tried_q    <= '0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      last_q     <= last_d;
      target_q   <= target_d;
      found_q    <= found_d;
      found_pw_q <= found_pw_d;
      tried_q    <= tried_d;
    end
  end

endmodule
